// File: rtl/rom_fetch_buffer.sv
// Sequential-address prefetcher in front of the SPI ROM reader: one read in flight,
// returned words queued in a small FIFO and handed to the core on a valid/ready stream.
module rom_fetch_buffer #(
   parameter int              DEPTH     = 4,
   parameter int              AW        = 24,
   parameter logic [AW-1:0]   BASE_ADDR = 24'h05_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          jump_en,
   input  logic [AW-1:0] jump_addr,
   output logic          rom_req,
   output logic [AW-1:0] rom_addr,
   input  logic [31:0]   rom_data,
   input  logic          rom_readyn,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic [AW-1:0] out_addr
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] fetch_addr;
   logic [PW-1:0] wptr, rptr;
   logic [PW:0]   count;
   logic [AW-1:0] mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];

   logic done, issue, push, pop;

   assign done  = ~rom_readyn;
   assign issue = (state == IDLE) & en & (count < FULL) & ~jump_en;
   assign push  = (state == WAIT) & done & ~jump_en;
   assign pop   = out_valid & out_ready & ~jump_en;

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem_data[rptr] : '0;
   assign out_addr  = out_valid ? mem_addr[rptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // A redirect during WAIT either kills the word returning this cycle or marks the
   // read for discard; the ROM response always ends a DROP so nothing can stall there.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (issue) state_nx = WAIT;
         WAIT: begin
            if (jump_en)   state_nx = done ? IDLE : DROP;
            else if (done) state_nx = IDLE;
         end
         DROP: if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_req    <= 1'b0;
         rom_addr   <= BASE_ADDR;
         fetch_addr <= BASE_ADDR;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
      end else begin
         rom_req <= issue;
         if (issue) rom_addr <= fetch_addr;
         if (jump_en) begin
            fetch_addr <= {jump_addr[AW-1:2], 2'b00};
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
         end else begin
            if (push) begin
               wptr       <= wptr + PW'(1);
               fetch_addr <= fetch_addr + AW'(4);
            end
            if (pop) rptr <= rptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + (PW+1)'(1);
               2'b01:   count <= count - (PW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wptr] <= rom_addr;
         mem_data[wptr] <= rom_data;
      end
   end

endmodule

// File: tb/tb_rom_fetch_buffer.sv
// Bench for rom_fetch_buffer: ROM responder, queue-based reference model checked every
// cycle, directed sequences, a jump-target vector table and a randomized phase.
module tb_rom_fetch_buffer;

   localparam int          AW    = 24;
   localparam int          DEPTH = 4;
   localparam logic [23:0] BASE  = 24'h05_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          jump_en = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic          rom_req;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data = '0;
   logic          rom_readyn = 1'b1;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_data;
   logic [AW-1:0] out_addr;

   rom_fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .en(en), .jump_en(jump_en), .jump_addr(jump_addr),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_readyn(rom_readyn),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int word_mode = 0;
   int lat = 10;
   int resp_cnt = -1;
   logic [23:0] resp_addr = '0;
   logic [23:0] req_log[$];

   // Reference model: queue of {addr,data}, next fetch address, outstanding-read flags.
   logic [55:0] mq[$];
   logic [23:0] m_fetch = BASE;
   logic [23:0] m_raddr = BASE;
   logic        m_pend = 1'b0;
   logic        m_drop = 1'b0;
   logic        m_req = 1'b0;

   typedef struct {
      logic [23:0]       jaddr;
      logic [3:0][23:0]  exp;
   } vec_t;
   vec_t vecs[4];

   function automatic logic [31:0] rom_word(input logic [23:0] a);
      if (word_mode == 0) return {8'h00, a};
      return {a[7:0] ^ 8'hC3, a ^ 24'h5A_A55A};
   endfunction

   function automatic logic [23:0] get_req(input int i);
      if (i < req_log.size()) return req_log[i];
      return 24'hBAD_BAD;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic ret, iss;
      if (rst) begin
         mq.delete();
         m_fetch = BASE; m_raddr = BASE;
         m_pend = 0; m_drop = 0; m_req = 0;
         return;
      end
      ret = !rom_readyn;
      iss = !m_pend && !m_drop && en && (mq.size() < DEPTH) && !jump_en;
      if (jump_en) begin
         mq.delete();
         m_fetch = {jump_addr[23:2], 2'b00};
         if (m_pend || m_drop) begin
            m_pend = 0;
            m_drop = !ret;
         end
      end else begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (m_pend && ret) begin
            mq.push_back({m_raddr, rom_word(m_raddr)});
            m_fetch = m_fetch + 24'd4;
            m_pend = 0;
         end else if (m_drop && ret) begin
            m_drop = 0;
         end
         if (iss) begin
            m_pend = 1;
            m_raddr = m_fetch;
         end
      end
      m_req = iss;
   endtask

   task automatic tick();
      logic [55:0] h;
      @(posedge clk);
      model_edge();
      #1;
      h = (mq.size() != 0) ? mq[0] : 56'h0;
      chk("model", {out_valid, out_data, out_addr, rom_req, rom_addr},
                   {mq.size() != 0, h[31:0], h[55:32], m_req, m_raddr});
      rom_readyn = 1'b1;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            rom_readyn = 1'b0;
            rom_data   = rom_word(resp_addr);
            resp_cnt   = -1;
         end
      end
      if (rom_req) begin
         req_log.push_back(rom_addr);
         resp_cnt  = (lat == 0) ? int'($urandom_range(1, 6)) : lat;
         resp_addr = rom_addr;
      end
   endtask

   task automatic set_vec(input int i, input logic [23:0] j, input logic [23:0] a0,
                          input logic [23:0] a1, input logic [23:0] a2, input logic [23:0] a3);
      vecs[i].jaddr  = j;
      vecs[i].exp[0] = a0;
      vecs[i].exp[1] = a1;
      vecs[i].exp[2] = a2;
      vecs[i].exp[3] = a3;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c, got;
      set_vec(0, 24'h01_2347, 24'h01_2344, 24'h01_2348, 24'h01_234C, 24'h01_2350);
      set_vec(1, 24'hFF_FFF8, 24'hFF_FFF8, 24'hFF_FFFC, 24'h00_0000, 24'h00_0004);
      set_vec(2, 24'hFF_FFFF, 24'hFF_FFFC, 24'h00_0000, 24'h00_0004, 24'h00_0008);
      set_vec(3, 24'h00_0000, 24'h00_0000, 24'h00_0004, 24'h00_0008, 24'h00_000C);

      // Reset state
      tick(); tick();
      rst = 0;
      chk("reset outputs", {out_valid, out_data, out_addr, rom_req, rom_addr},
                           {1'b0, 32'h0, 24'h0, 1'b0, BASE});

      // Fill the FIFO from BASE with out_ready low
      req_log.delete();
      en = 1;
      for (int i = 0; i < 80; i++) tick();
      chk("fill req count", req_log.size(), 4);
      chk("fill req0", get_req(0), 24'h05_0000);
      chk("fill req1", get_req(1), 24'h05_0004);
      chk("fill req2", get_req(2), 24'h05_0008);
      chk("fill req3", get_req(3), 24'h05_000C);
      chk("fill head", {out_valid, out_addr, out_data}, {1'b1, 24'h05_0000, 32'h0005_0000});

      // One pop from full: exactly one refill read
      out_ready = 1; tick(); out_ready = 0;
      for (int i = 0; i < 40; i++) tick();
      chk("refill req count", req_log.size(), 5);
      chk("refill addr", get_req(4), 24'h05_0010);
      chk("refill head", out_addr, 24'h05_0004);

      // Jump while a read is in flight
      out_ready = 1; tick(); out_ready = 0;
      for (c = 0; c < 10 && !rom_req; c++) tick();
      chk("jump-wait req seen", rom_req, 1'b1);
      tick(); tick();
      n = req_log.size();
      jump_en = 1; jump_addr = 24'h01_2347; tick(); jump_en = 0;
      chk("jump-wait flush", out_valid, 1'b0);
      for (c = 0; c < 60 && !out_valid; c++) tick();
      chk("jump-wait first out", {out_valid, out_addr}, {1'b1, 24'h01_2344});
      chk("jump-wait next req", get_req(n), 24'h01_2344);

      // Jump in the same cycle the ROM returns a word
      for (c = 0; c < 60 && rom_readyn !== 1'b0; c++) tick();
      chk("jump-ret pulse seen", rom_readyn, 1'b0);
      jump_en = 1; jump_addr = 24'h00_1230; tick(); jump_en = 0;
      chk("jump-ret flush", out_valid, 1'b0);
      tick();
      chk("jump-ret immediate req", {rom_req, rom_addr}, {1'b1, 24'h00_1230});
      for (c = 0; c < 60 && !out_valid; c++) tick();
      chk("jump-ret first out", {out_valid, out_addr}, {1'b1, 24'h00_1230});

      // Jump-target table with sustained pops (includes address wrap)
      lat = 2; out_ready = 1; en = 1;
      foreach (vecs[v]) begin
         jump_en = 1; jump_addr = vecs[v].jaddr; tick(); jump_en = 0;
         got = 0;
         for (c = 0; c < 200 && got < 4; c++) begin
            if (out_valid) begin
               chk($sformatf("vec%0d addr%0d", v, got), out_addr, vecs[v].exp[got]);
               if (got == 0) chk($sformatf("vec%0d data0", v), out_data, {8'h00, vecs[v].exp[0]});
               got++;
            end
            tick();
         end
         chk($sformatf("vec%0d words", v), got, 4);
      end

      // Reset mid-read with two entries queued, then a stray ROM pulse
      lat = 10; out_ready = 0;
      jump_en = 1; jump_addr = 24'h05_0100; tick(); jump_en = 0;
      for (c = 0; c < 200 && !(mq.size() == 2 && m_pend); c++) tick();
      chk("rst setup", {out_valid, out_addr}, {1'b1, 24'h05_0100});
      rst = 1; resp_cnt = -1; tick(); rst = 0;
      chk("rst mid-wait", {out_valid, rom_req, rom_addr}, {1'b0, 1'b0, BASE});
      en = 0;
      rom_readyn = 0; rom_data = 32'h1234_5678; tick(); tick();
      chk("stray pulse ignored", {out_valid, rom_req}, 2'b00);

      // Randomized phase
      word_mode = 1; lat = 0;
      rst = 1; resp_cnt = -1; tick(); rst = 0;
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(0, 3) != 0);
         out_ready = $urandom_range(0, 1);
         jump_en   = ($urandom_range(0, 31) == 0);
         jump_addr = $urandom_range(0, 1) ? 24'($urandom) : (24'hFF_FFF0 | 24'($urandom_range(0, 15)));
         rst       = ($urandom_range(0, 199) == 0);
         if (rst) resp_cnt = -1;
         tick();
      end
      rst = 0; jump_en = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_fetch_buffer.md
Name: rom_fetch_buffer

Overview:
- Prefetch stage directly upstream of the Parallel_ROM SPI flash reader; it also consumes the reader's 32-bit words.
- Generates sequential word addresses starting at a boot base, issues one ROM read at a time, and queues returned words in a small FIFO.
- Presents queued words to the core fetch logic on a valid/ready stream.
- Supports a jump/redirect that flushes queued data and drops any read already in flight.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16)
- BASE_ADDR, 24'h05_0000, fetch address after reset (word aligned)
- AW, 24, ROM byte-address width

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  1 = new reads may be issued; 0 = no new issue (an in-flight read still completes)
- jump_en  input  1  one-cycle redirect strobe
- jump_addr  input  AW  redirect target; bits [1:0] are ignored
- rom_req  output  1  one-cycle read strobe to the ROM reader
- rom_addr  output  AW  read address; held stable from rom_req until completion
- rom_data  input  32  word returned by the ROM reader
- rom_readyn  input  1  active-low; low for exactly one cycle when rom_data is valid
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts the head word
- out_data  output  32  head word
- out_addr  output  AW  ROM address of the head word

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, count=0, fetch_addr=BASE_ADDR.
  - rom_req=0, rom_addr=BASE_ADDR, out_valid=0, out_data=0, out_addr=0.
  - The ROM reader shares this reset, so no response from before reset is ever accepted.
- Internal state: fetch_addr register; a FIFO of {addr, data} pairs with wptr/rptr/count; a 3-state FSM.
- FSM states: IDLE, WAIT, DROP.
- IDLE: if en=1, count<DEPTH and jump_en=0:
  - assert rom_req=1 for one cycle; rom_addr<=fetch_addr; go to WAIT.
  - rom_readyn low while in IDLE is ignored.
- WAIT: on rom_readyn=0:
  - push {rom_addr, rom_data}; fetch_addr<=fetch_addr+4 (wraps modulo 2^AW); go to IDLE.
  - Earliest next rom_req is the cycle after return, so one transaction is outstanding at most.
- DROP: on rom_readyn=0, discard rom_data, do not change fetch_addr, go to IDLE.
- Jump (highest priority, any state):
  - count<=0 and pointers reset; fetch_addr<=jump_addr with bits [1:0] cleared.
  - IDLE: stay in IDLE; the next read issues the following cycle.
  - WAIT with rom_readyn=1: go to DROP.
  - WAIT with rom_readyn=0 in the same cycle: discard the word, go to IDLE.
  - DROP: update fetch_addr and remain in DROP.
  - No rom_req is issued in a jump cycle.
- Overflow cannot occur, because a read issues only when count<DEPTH and at most one read is outstanding.
- Output side:
  - out_valid = (count != 0); out_data/out_addr show the head entry combinationally from storage.
  - Pop when out_valid & out_ready & ~jump_en.
  - Push and pop in the same cycle leave count unchanged.
  - Pop while empty is ignored.
  - Jump and pop in the same cycle: flush wins.
- Ordering: words leave the FIFO in strictly increasing address order between jumps.
- Address arithmetic: unsigned AW bits; fetch_addr 24'hFF_FFFC + 4 = 24'h00_0000.
- en=0 mid-WAIT: the read completes and pushes normally; no further issue until en=1.
- Latency: the first word after reset reaches out_valid one cycle after the rom_readyn pulse that returns it.

Test Plan:
1. Reset then en=1; ROM model returns word = address after 10 cycles. Required: rom_req at BASE_ADDR, then 05_0004, 05_0008, 05_000C; 4 entries queued; no 5th rom_req while out_ready=0.
2. Full FIFO, then out_ready=1 for one cycle. Required: head (05_0000, 0x00050000) is popped; exactly one new rom_req at 05_0010 follows.
3. jump_en with jump_addr=24'h01_2347 during WAIT. Required: out_valid=0 next cycle; the in-flight word is dropped; next rom_req at 01_2344; first output is addr 01_2344.
4. jump_en in the same cycle as rom_readyn=0. Required: that word is never output; state returns to IDLE; next rom_req at the jump target.
5. jump_addr=24'hFF_FFF8 with sustained pops. Required: output addresses FF_FFF8, FF_FFFC, 00_0000, 00_0004.
6. rst asserted mid-WAIT with 2 entries queued. Required: next cycle out_valid=0, rom_req=0, rom_addr=BASE_ADDR; a stray rom_readyn pulse in IDLE pushes nothing.
